// File: rtl/mskaes_inv_mc_column_sequencer_pkg.sv
// Shared definitions for the masked inverse-MixColumns column sequencer.
// Holds the FSM encoding, the AES state geometry, and the helpers that map a
// byte or column index to its bit offset in a d-share interleaved state
// (byte k occupies BYTE_W*d bits starting at BYTE_W*d*k).
package mskaes_inv_mc_column_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int BYTE_W    = 8;
  localparam int COL_BYTES = 4;
  localparam int NCOL      = 4;

  function automatic int byte_off(input int d, input int k);
    return BYTE_W * d * k;
  endfunction

  function automatic int col_off(input int d, input int c);
    return byte_off(d, COL_BYTES * c);
  endfunction

endpackage

// File: rtl/mskaes_inv_mc_column_sequencer_if.sv
// Bus bundle between the column sequencer, its upstream/downstream handshake
// partners and the combinational masked inverse-MixColumns stage.
//   in_*   : input state handshake (valid/ready, bypass flag, 128*D data)
//   out_*  : mixed state handshake (valid/ready, 128*D data)
//   mc_a*  : rows 0..3 of the current column, towards the MixColumns stage
//   mc_b*  : rows 0..3 returned by the MixColumns stage (same cycle)
// slave  = the sequencer's view; master = everything around it.
interface mskaes_inv_mc_column_sequencer_if #(
  parameter int D = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              in_bypass;
  logic [128*D-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [128*D-1:0]  out_data;
  logic [8*D-1:0]    mc_a0, mc_a1, mc_a2, mc_a3;
  logic [8*D-1:0]    mc_b0, mc_b1, mc_b2, mc_b3;

  modport slave (
    input  in_valid, in_bypass, in_data, out_ready,
           mc_b0, mc_b1, mc_b2, mc_b3,
    output in_ready, out_valid, out_data,
           mc_a0, mc_a1, mc_a2, mc_a3
  );

  modport master (
    output in_valid, in_bypass, in_data, out_ready,
           mc_b0, mc_b1, mc_b2, mc_b3,
    input  in_ready, out_valid, out_data,
           mc_a0, mc_a1, mc_a2, mc_a3
  );
endinterface

// File: rtl/mskaes_share_col_select.sv
// Column selector for a d-share masked AES state.
//   sel_i   : public 2-bit column index
//   en_i    : write-back enable (asserted while mixing)
//   state_i : full masked state, byte k at [8*D*k +: 8*D]
//   col_o   : selected column, row r in col_o[r]
//   we_o    : one-hot column write enable (all zero when en_i is low)
// Whole masked bytes are moved as units, so every output bit comes from the
// same share index of the same source bit; only the public select steers it.
module mskaes_share_col_select
  import mskaes_inv_mc_column_sequencer_pkg::*;
#(
  parameter int D = 2
) (
  input  logic [1:0]                            sel_i,
  input  logic                                  en_i,
  input  logic [128*D-1:0]                      state_i,
  output logic [COL_BYTES-1:0][BYTE_W*D-1:0]    col_o,
  output logic [NCOL-1:0]                       we_o
);

  logic [NCOL-1:0][COL_BYTES*BYTE_W*D-1:0] cols;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    assign cols[c] = state_i[col_off(D, c) +: COL_BYTES*BYTE_W*D];
  end

  assign col_o = cols[sel_i];

  always_comb begin
    we_o        = '0;
    we_o[sel_i] = en_i;
  end

endmodule

// File: rtl/mskaes_inv_mc_column_sequencer.sv
// Sequencer feeding a masked inverse-MixColumns stage one column per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of the sequencer bus (input handshake, output
//              handshake, mc_a*/mc_b* column exchange with the MC stage)
// A state is loaded in IDLE (or in HOLD while the previous result is being
// taken), mixed over four MIX cycles (skipped when bypass is set), then held
// in HOLD until downstream accepts it. All datapath moves are share-wise.
module mskaes_inv_mc_column_sequencer
  import mskaes_inv_mc_column_sequencer_pkg::*;
#(
  parameter int D = 2
) (
  input logic                            clk,
  input logic                            rst,
  mskaes_inv_mc_column_sequencer_if.slave bus
);

  state_e                              st_q, st_d;
  logic [1:0]                          col_q, col_d;
  logic                                byp_q, byp_d;
  logic [128*D-1:0]                    state_q, state_d;

  logic                                in_rdy;
  logic                                load;
  logic                                mix_en;
  logic [COL_BYTES-1:0][BYTE_W*D-1:0]  col_a;
  logic [COL_BYTES-1:0][BYTE_W*D-1:0]  col_b;
  logic [NCOL-1:0]                     col_we;

  // A bypassed transaction must never write back, even if the FSM were upset.
  assign mix_en = (st_q == ST_MIX) && !byp_q;
  assign load   = bus.in_valid && in_rdy;
  assign col_b  = {bus.mc_b3, bus.mc_b2, bus.mc_b1, bus.mc_b0};

  // col_q is 0 outside MIX, so mc_a* carry column 0 there; the mux is fed only
  // by registers, keeping in_data off the MC-stage inputs.
  mskaes_share_col_select #(.D(D)) u_col_sel (
    .sel_i   (col_q),
    .en_i    (mix_en),
    .state_i (state_q),
    .col_o   (col_a),
    .we_o    (col_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      col_q   <= 2'd0;
      byp_q   <= 1'b0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      col_q   <= col_d;
      byp_q   <= byp_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    col_d   = col_q;
    byp_d   = byp_q;
    state_d = state_q;
    case (st_q)
      ST_IDLE: ;
      ST_MIX: begin
        for (int c = 0; c < NCOL; c++) begin
          if (col_we[c]) state_d[col_off(D, c) +: COL_BYTES*BYTE_W*D] = col_b;
        end
        // 3 -> 0 wrap happens here, leaving col at 0 for HOLD/IDLE.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) st_d = ST_HOLD;
      end
      ST_HOLD: if (bus.out_ready) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = bus.in_data;
      byp_d   = bus.in_bypass;
      col_d   = 2'd0;
      st_d    = bus.in_bypass ? ST_HOLD : ST_MIX;
    end
  end

  always_comb begin
    in_rdy        = (st_q == ST_IDLE) || ((st_q == ST_HOLD) && bus.out_ready);
    bus.in_ready  = in_rdy;
    bus.out_valid = (st_q == ST_HOLD);
    bus.out_data  = state_q;
    bus.mc_a0     = col_a[0];
    bus.mc_a1     = col_a[1];
    bus.mc_a2     = col_a[2];
    bus.mc_a3     = col_a[3];
  end

endmodule

// File: tb/tb_mskaes_inv_mc_column_sequencer.sv
module tb_mskaes_inv_mc_column_sequencer;
  localparam int D = 2;
  localparam int W = 128 * D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mskaes_inv_mc_column_sequencer_if #(.D(D)) bus ();

  mskaes_inv_mc_column_sequencer #(.D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(a); x4 = xt(x2); x8 = xt(x4);
    case (c)
      4'h9:    return x8 ^ a;
      4'hb:    return x8 ^ x2 ^ a;
      4'hd:    return x8 ^ x4 ^ a;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  // column with row r at [8r +: 8]
  function automatic logic [31:0] invmc_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3, r0, r1, r2, r3;
    a0 = a[7:0]; a1 = a[15:8]; a2 = a[23:16]; a3 = a[31:24];
    r0 = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
    r1 = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
    r2 = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
    r3 = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [127:0] invmc_plain(input logic [127:0] v);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = invmc_col(v[32*c +: 32]);
    return r;
  endfunction

  // words written row0-first (row0 is the most significant byte of the word)
  function automatic logic [127:0] cols2plain(input logic [31:0] w0, w1, w2, w3);
    logic [3:0][31:0] w;
    logic [127:0] v;
    w = {w3, w2, w1, w0};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) v[32*c + 8*r +: 8] = w[c][31-8*r -: 8];
    return v;
  endfunction

  function automatic logic [127:0] get_share(input logic [W-1:0] x, input int i);
    logic [127:0] s;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 8; j++) s[8*k+j] = x[16*k + 2*j + i];
    return s;
  endfunction

  function automatic logic [W-1:0] put_shares(input logic [127:0] s0, s1);
    logic [W-1:0] x;
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 8; j++) begin
        x[16*k + 2*j]     = s0[8*k+j];
        x[16*k + 2*j + 1] = s1[8*k+j];
      end
    return x;
  endfunction

  function automatic logic [W-1:0] mask(input logic [127:0] v, m);
    return put_shares(v ^ m, m);
  endfunction

  function automatic logic [127:0] unmask(input logic [W-1:0] x);
    return get_share(x, 0) ^ get_share(x, 1);
  endfunction

  function automatic logic [W-1:0] sharewise_invmc(input logic [W-1:0] x);
    return put_shares(invmc_plain(get_share(x, 0)), invmc_plain(get_share(x, 1)));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- masked inverse-MixColumns stage (share-wise, linear) ----------------
  logic [3:0][8*D-1:0] ma, mb;
  logic [31:0] sa, sb;
  assign ma = {bus.mc_a3, bus.mc_a2, bus.mc_a1, bus.mc_a0};
  assign bus.mc_b0 = mb[0];
  assign bus.mc_b1 = mb[1];
  assign bus.mc_b2 = mb[2];
  assign bus.mc_b3 = mb[3];

  always_comb begin
    mb = '0;
    sa = '0;
    sb = '0;
    for (int i = 0; i < D; i++) begin
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 8; j++) sa[8*r+j] = ma[r][D*j+i];
      sb = invmc_col(sa);
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 8; j++) mb[r][D*j+i] = sb[8*r+j];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] data;
    logic [127:0] plain;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   seen    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected no transaction", bus.out_data);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", cyc - q[0].acc, q[0].lat);
        end
        if (bus.out_ready) begin
          chk("out_shares", bus.out_data, q[0].data);
          chk("out_plain", unmask(bus.out_data), q[0].plain);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [W-1:0] x, input bit byp, input logic [127:0] plain,
                      output int tries);
    bit acc;
    exp_t e;
    acc   = 1'b0;
    tries = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    bus.in_bypass = byp;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", tries);
    end else begin
      e.data  = byp ? x : sharewise_invmc(x);
      e.plain = plain;
      e.acc   = cyc;
      e.lat   = byp ? 0 : 4;
      q.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] v, m, v2, ve;
    logic [W-1:0] x;
    int tr;

    bus.in_valid  = 1'b0;
    bus.in_bypass = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_mc_a0", bus.mc_a0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // basic mix
    v  = cols2plain(32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101);
    ve = cols2plain(32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'h01010101);
    m  = rnd128();
    send(mask(v, m), 1'b0, ve, tr);
    drain();

    // bypass
    send(mask(v, m), 1'b1, v, tr);
    drain();

    // backpressure, with a competing input held during the stall
    v2 = rnd128();
    x  = mask(v2, rnd128());
    bus.out_ready = 1'b0;
    send(x, 1'b0, invmc_plain(v2), tr);
    bus.in_valid = 1'b1;
    bus.in_data  = mask(v, m);
    bus.in_bypass = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_data", bus.out_data, sharewise_invmc(x));
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(mask(v, m), 1'b1, v, tr);
    chk("bp_same_edge_accept", tr, 1);
    drain();

    // back-to-back, alternating bypass
    for (int i = 0; i < 8; i++) begin
      v2 = rnd128();
      send(mask(v2, rnd128()), i[0], i[0] ? v2 : invmc_plain(v2), tr);
    end
    drain();

    // reset while mixing column 2
    v2 = rnd128();
    send(mask(v2, rnd128()), 1'b0, invmc_plain(v2), tr);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_mc_a0", bus.mc_a0, 0);
    q.delete();
    seen = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1 chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(mask(v, m), 1'b0, ve, tr);
    drain();

    // share independence: same value, different masks
    v2 = rnd128();
    send(mask(v2, rnd128()), 1'b0, invmc_plain(v2), tr);
    send(mask(v2, rnd128()), 1'b0, invmc_plain(v2), tr);
    send(mask(v2, '0), 1'b0, invmc_plain(v2), tr);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mskaes_inv_mc_column_sequencer.md
Name: mskaes_inv_mc_column_sequencer

Overview:
- Sequential driver that sits directly upstream of the masked inverse-MixColumns combinational stage in the decryption datapath.
- Accepts a full d-share masked 128-bit state and presents it one column (4 masked bytes) per cycle to the inverse-MixColumns stage.
- Writes each returned column back into its state register, then offers the mixed state downstream over a valid/ready handshake.
- Supports a per-transaction bypass for the final decryption round, where inverse MixColumns is skipped.

Parameters:
- d, 2, number of shares (masking order d-1); must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept an input state.
- in_bypass  in  1  sampled with in_data; 1 = skip inverse MixColumns.
- in_data  in  128*d  masked state; byte k at [8*d*k +: 8*d]; inside a byte, bit j of share i at index d*j+i.
- mc_a0, mc_a1, mc_a2, mc_a3  out  8*d each  rows 0..3 of the current column, to the inverse-MixColumns inputs.
- mc_b0, mc_b1, mc_b2, mc_b3  in  8*d each  rows 0..3 returned by the inverse-MixColumns stage (same cycle, combinational).
- out_valid  out  1  mixed state available.
- out_ready  in  1  downstream accepts.
- out_data  out  128*d  mixed masked state, same layout as in_data.

Behaviour:
- Column c = bytes 4c..4c+3; byte 4c+r drives mc_a<r>.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data into the state register and latch the bypass flag. bypass=0 -> MIX with col=0; bypass=1 -> HOLD.
  - MIX: mc_a* = column col of the state register. At each edge, the mc_b* column is written into column col and col increments. After col=3 is written -> HOLD.
  - HOLD: out_valid=1 and out_data = state register.
    - out_valid&out_ready -> IDLE.
    - If in_valid is also high while out_ready=1: in_ready=1 in HOLD, and the new state is loaded in the same edge. The next state follows the new bypass flag (MIX col=0, or HOLD).
- Latency, with input accepted at edge t:
  - bypass=0: out_valid rises after edge t+4, giving 4 MIX cycles.
  - bypass=1: out_valid rises after edge t+0, giving a 1-cycle path.
  - Throughput with out_ready held high: one state per 5 cycles (bypass=0) or per cycle (bypass=1).
- in_ready = IDLE | (HOLD & out_ready); it is never asserted in MIX.
- out_data is stable from out_valid rising until the handshake completes.
- mc_a* outputs:
  - Driven only from registers, so no combinational path from in_data to mc_a*.
  - Outside MIX, they carry column 0 of the state register (no share recombination, no glitch path across shares).
- Sharewise only: the block never XORs, combines or muxes bits of different shares into one wire. Every mux select is public (FSM/col).
- Column counter is 2 bits. It wraps 3->0 only on the MIX->HOLD transition and is forced to 0 on any load.
- Reset (asynchronous, at any time including mid-MIX):
  - FSM goes to IDLE, col=0, bypass flag=0, state register all-zero.
  - Outputs: out_valid=0, in_ready=1 once rst deasserts, out_data=0, mc_a*=0.
  - Any partially mixed state is discarded. The first accepted input after reset behaves exactly as from power-up.
- in_data/in_bypass are don't-care unless in_valid&in_ready.
- out_ready is don't-care outside HOLD.

Decomposition:
- Shared package: FSM state encoding (IDLE/MIX/HOLD); constants BYTE_W=8, COL_BYTES=4, NCOL=4; share-sliced byte/column index helpers (byte k -> offset 8*d*k).
- One sub-module: mskaes_share_col_select. A 4:1 column mux plus column write-enable decode, parameterised by d, with a public 2-bit select.
- FSM and registers stay in the top.

Test Plan:
All vectors use d=2, share1 = random mask m, share0 = value^m. The bench instantiates the masked inverse-MixColumns stage on mc_a*/mc_b*. Final checks compare the XOR of shares against the expected values.
- Basic mix:
  - Stimulus: columns 8e4da1bc, 9fdc589d, c6c6c6c6, 01010101 (row0 first), bypass=0.
  - Required: out_valid after exactly 4 MIX cycles; unmasked columns db135345, f20a225c, c6c6c6c6, 01010101.
- Bypass:
  - Stimulus: same input with bypass=1.
  - Required: out_valid one edge after acceptance; out_data bit-identical to in_data, shares included.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles in HOLD.
  - Required: out_data stable and in_ready=0 throughout. On out_ready=1 with in_valid=1, the next state is accepted on the same edge.
- Back-to-back:
  - Stimulus: 8 random states, alternating bypass, out_ready=1.
  - Required: results in order, matching the golden unmasked inverse MixColumns. No extra or lost transactions.
- Reset mid-operation:
  - Stimulus: rst asserted asynchronously during MIX col=2.
  - Required: out_valid=0 and out_data=0 immediately. in_ready=1 after release. The next transaction is correct.
- Share independence:
  - Stimulus: flip share1 masks only, keeping the unmasked value fixed.
  - Required: the unmasked result is unchanged; each output share depends only on the same-index input share.
